// File: rtl/cpu7_ifu_imem_bridge_if.sv
// cpu7_ifu_imem_bridge_if: fetch-request and instruction-bus bundles for the IFU memory bridge
//   cpu7_ifu_imem_bridge_if: IFU side. The IFU (master) drives req/addr/cancel; the bridge (slave)
//     returns addr_ok/busy and the registered response valid_f/rdata_f/ex/exccode/count/uncache.
//   cpu7_ibus_if: bus side. The bridge (master) drives req/addr; the memory (slave) returns
//     addr_ok/data_ok/rdata.
interface cpu7_ifu_imem_bridge_if #(parameter int GRLEN = 32);
  logic             req;
  logic [31:0]      addr;
  logic             cancel;
  logic             addr_ok;
  logic             busy;
  logic             valid_f;
  logic [GRLEN-1:0] rdata_f;
  logic             ex;
  logic [5:0]       exccode;
  logic [1:0]       count;
  logic             uncache;
  modport master (output req, addr, cancel,
                  input  addr_ok, busy, valid_f, rdata_f, ex, exccode, count, uncache);
  modport slave  (input  req, addr, cancel,
                  output addr_ok, busy, valid_f, rdata_f, ex, exccode, count, uncache);
endinterface

interface cpu7_ibus_if;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  modport master (output req, addr, input  addr_ok, data_ok, rdata);
  modport slave  (input  req, addr, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/cpu7_ifu_imem_bridge.sv
// cpu7_ifu_imem_bridge: one-outstanding fetch bridge from the IFU request port to an SRAM-like instruction bus
//   clk   : single clock, all state on the rising edge
//   rst_l : synchronous active-low reset
//   inst  : IFU side (slave) - request/cancel in, accept/busy and one-cycle response pulse out
//   ibus  : bus side (master) - address handshake out, addr_ok/data_ok/rdata in
module cpu7_ifu_imem_bridge #(
  parameter int         GRLEN       = 32,
  parameter logic [2:0] UNCACHE_SEG = 3'b101,
  parameter logic [5:0] EXC_ADEF    = 6'h08
) (
  input  logic                  clk,
  input  logic                  rst_l,
  cpu7_ifu_imem_bridge_if.slave inst,
  cpu7_ibus_if.master           ibus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  logic [1:0]       state, state_n;
  logic             drop;
  logic [31:0]      addr_q;
  logic             valid_q, ex_q, unc_q;
  logic [5:0]       code_q;
  logic [GRLEN-1:0] rdata_q;
  logic             accept, misaligned, adef, deliver;
  assign accept     = state == IDLE && inst.req;
  assign misaligned = |inst.addr[1:0];
  assign adef       = accept && misaligned;
  // cancel arriving together with data_ok also kills the word, drop or not
  assign deliver    = state == DATA && ibus.data_ok && !drop && !inst.cancel;
  always_comb
    state_n = state == IDLE ? (accept && !misaligned ? REQ : IDLE) :
              state == REQ  ? (ibus.addr_ok ? DATA : REQ) :
              state == DATA ? (ibus.data_ok ? IDLE : DATA) : IDLE;
  always_ff @(posedge clk)
    if (!rst_l) begin
      state   <= IDLE;
      drop    <= 1'b0;
      addr_q  <= '0;
      unc_q   <= 1'b0;
      valid_q <= 1'b0;
      ex_q    <= 1'b0;
      code_q  <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_n;
      // the response closes the transaction, so it wins over a fresh cancel
      drop    <= state == DATA && ibus.data_ok ? 1'b0 : state != IDLE && inst.cancel ? 1'b1 : drop;
      if (accept && !misaligned) begin
        addr_q <= inst.addr;
        unc_q  <= inst.addr[31:29] == UNCACHE_SEG;
      end
      valid_q <= adef || deliver;
      ex_q    <= adef;
      code_q  <= adef ? EXC_ADEF : '0;
      rdata_q <= deliver ? GRLEN'(ibus.rdata) : '0;
    end
  assign inst.addr_ok = accept;
  assign inst.busy    = state != IDLE;
  assign inst.valid_f = valid_q;
  assign inst.rdata_f = rdata_q;
  assign inst.ex      = ex_q;
  assign inst.exccode = code_q;
  assign inst.count   = valid_q ? 2'd1 : 2'd0;
  assign inst.uncache = unc_q;
  assign ibus.req     = state == REQ;
  assign ibus.addr    = addr_q;
endmodule
